mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port 16x8 register memory (4-bit address, 8-bit data, combinational read, write on rising clk edge) between two independent masters. It samples requests, selects one winner per transaction, drives the memory's address/data/write inputs from registers and returns a one-cycle acknowledge with read data to the winner. It sits between the two masters (e.g. control unit and a loader/debug port) and the memory instance.

---
 rtl/mem_arbiter_if.sv | 26 ++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_arbiter_if                                          |
// | Description : Request/acknowledge bundle between one memory master    |
// |               and the arbiter.                                        |
// |   req   : transaction request, held until ack                         |
// |   we    : 1 = write, 0 = read (stable while req)                      |
// |   addr  : 4-bit word address (stable while req)                       |
// |   wdata : 8-bit write data (stable while req)                         |
// |   ack   : one-cycle completion pulse                                  |
// |   rdata : registered read data, valid from the ack cycle              |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
interface mem_arbiter_if;
  logic       req;
  logic       we;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       ack;
  logic [7:0] rdata;

  // Master issues transactions, slave (the arbiter) completes them.
  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_arbiter                                             |
// | Description : Shares a single-port 16x8 memory (combinational read,   |
// |               write on rising clk) between two masters. One winner    |
// |               per transaction; IDLE -> ACCESS -> DONE, one            |
// |               transaction every 3 cycles.                             |
// | Ports       :                                                         |
// |   clk            : system clock                                       |
// |   rst_n          : asynchronous active-low reset                      |
// |   rq0_if, rq1_if : requester bundles (slave side)                     |
// |   mem_address_o  : memory address (registered)                        |
// |   mem_data_in_o  : memory write data (registered)                     |
// |   mem_write_o    : memory write enable, high only in ACCESS           |
// |   mem_data_out_i : memory read data                                   |
// |   busy_o         : high whenever the arbiter is not IDLE              |
// | Options     : MEM_ARB_FIXED_PRIO_EN - requester 0 always wins         |
// |               simultaneous requests (no round-robin pointer).         |
// |               Undefined (default): round-robin.                       |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module mem_arbiter (
  input  wire logic       clk,
  input  wire logic       rst_n,
  mem_arbiter_if.slave    rq0_if,
  mem_arbiter_if.slave    rq1_if,
  output logic [3:0]      mem_address_o,
  output logic [7:0]      mem_data_in_o,
  output logic            mem_write_o,
  input  wire logic [7:0] mem_data_out_i,
  output logic            busy_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0] state_q,  state_d;
  logic       winner_q, winner_d;
  logic [3:0] addr_q,   addr_d;
  logic [7:0] wdata_q,  wdata_d;
  logic       write_q,  write_d;
  logic       ack0_q,   ack0_d;
  logic       ack1_q,   ack1_d;
  logic [7:0] rdata0_q, rdata0_d;
  logic [7:0] rdata1_q, rdata1_d;

  logic       w_any_req;
  logic       w_grant;   // 0 = requester 0 wins, 1 = requester 1 wins

  assign w_any_req = rq0_if.req | rq1_if.req;

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Requester 1 only wins when requester 0 is silent.
  assign w_grant = ~rq0_if.req;
`else
  logic ptr_q, ptr_d;

  // A lone requester always wins; a tie goes to the pointer side.
  assign w_grant = (rq0_if.req & rq1_if.req) ? ptr_q : rq1_if.req;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_IDLE && w_any_req) begin
      ptr_d = ~w_grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = 1'b0;      // write enable only survives into ACCESS
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    case (state_q)
      S_IDLE: begin
        if (w_any_req) begin
          winner_d = w_grant;
          addr_d   = w_grant ? rq1_if.addr  : rq0_if.addr;
          wdata_d  = w_grant ? rq1_if.wdata : rq0_if.wdata;
          write_d  = w_grant ? rq1_if.we    : rq0_if.we;
          state_d  = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // Capture read data at the same edge the memory would write, so a
        // read sees the contents before that edge.
        if (!write_q) begin
          if (winner_q) rdata1_d = mem_data_out_i;
          else          rdata0_d = mem_data_out_i;
        end
        ack0_d  = ~winner_q;
        ack1_d  = winner_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        // Requests are deliberately ignored here: the winner still holds
        // req during its ack cycle.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Async reset clears mem_write immediately, so an in-flight write is
  // dropped before its memory edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      winner_q <= 1'b0;
      addr_q   <= 4'd0;
      wdata_q  <= 8'd0;
      write_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= 8'd0;
      rdata1_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign mem_address_o = addr_q;
  assign mem_data_in_o = wdata_q;
  assign mem_write_o   = write_q;
  assign busy_o        = (state_q != S_IDLE);

  assign rq0_if.ack   = ack0_q;
  assign rq0_if.rdata = rdata0_q;
  assign rq1_if.ack   = ack1_q;
  assign rq1_if.rdata = rdata1_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                          |
// | Description : Directed self-checking bench for mem_arbiter with a     |
// |               16x8 memory model (initial contents addr*0x11).         |
// | Options     : honours MEM_ARB_FIXED_PRIO_EN for tie expectations.     |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] mem_address;
  logic [7:0] mem_data_in;
  logic       mem_write;
  logic [7:0] mem_data_out;
  logic       busy;
  logic       mem_init;

  logic [7:0] mem_model [16];

  int n_tests;
  int n_fail;

  mem_arbiter_if m0 ();
  mem_arbiter_if m1 ();

  mem_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rq0_if         (m0),
    .rq1_if         (m1),
    .mem_address_o  (mem_address),
    .mem_data_in_o  (mem_data_in),
    .mem_write_o    (mem_write),
    .mem_data_out_i (mem_data_out),
    .busy_o         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write on rising edge.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem_model[i] <= 8'(i * 8'h11);
    end else if (mem_write) begin
      mem_model[mem_address] <= mem_data_in;
    end
  end
  assign mem_data_out = mem_model[mem_address];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transaction from a single requester; inputs change on negedge,
  // outputs are sampled on negedge.
  task automatic run_txn(input bit who, input bit we, input logic [3:0] a,
                         input logic [7:0] d, input logic [7:0] exp_rd,
                         input string tag);
    int  n;
    bit  got;
    bit  other;
    n = 0; got = 0; other = 0;
    if (!who) begin m0.req = 1'b1; m0.we = we; m0.addr = a; m0.wdata = d; end
    else      begin m1.req = 1'b1; m1.we = we; m1.addr = a; m1.wdata = d; end
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (who ? m1.ack : m0.ack) got = 1;
      if (who ? m0.ack : m1.ack) other = 1;
    end
    check({tag, "_latency"}, n, 2);
    check({tag, "_other_ack"}, 32'(other), 0);
    check({tag, "_rdata"}, who ? m1.rdata : m0.rdata, exp_rd);
    m0.req = 1'b0;
    m1.req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] exp_ack;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    mem_init = 1'b1;
    m0.req = 0; m0.we = 0; m0.addr = 0; m0.wdata = 0;
    m1.req = 0; m1.we = 0; m1.addr = 0; m1.wdata = 0;
    repeat (2) @(negedge clk);
    mem_init = 1'b0;

    // Reset state
    check("rst_ack0",   32'(m0.ack), 0);
    check("rst_ack1",   32'(m1.ack), 0);
    check("rst_rdata0", m0.rdata, 0);
    check("rst_rdata1", m1.rdata, 0);
    check("rst_mem_write", 32'(mem_write), 0);
    check("rst_mem_address", mem_address, 0);
    check("rst_mem_data_in", mem_data_in, 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Requester 0 writes 0xA5 to addr 3, detailed cycle checks
    m0.req = 1'b1; m0.we = 1'b1; m0.addr = 4'd3; m0.wdata = 8'hA5;
    @(negedge clk);   // ACCESS
    check("wr_access_busy", 32'(busy), 1);
    check("wr_access_mem_write", 32'(mem_write), 1);
    check("wr_access_addr", mem_address, 3);
    check("wr_access_data", mem_data_in, 8'hA5);
    check("wr_access_ack0", 32'(m0.ack), 0);
    @(negedge clk);   // DONE
    check("wr_done_ack0", 32'(m0.ack), 1);
    check("wr_done_ack1", 32'(m1.ack), 0);
    check("wr_done_mem_write", 32'(mem_write), 0);
    check("wr_done_rdata0", m0.rdata, 0);
    check("wr_mem_contents", mem_model[3], 8'hA5);
    m0.req = 1'b0;
    @(negedge clk);   // IDLE
    check("wr_idle_ack0", 32'(m0.ack), 0);
    check("wr_idle_busy", 32'(busy), 0);

    // Requester 1 reads addr 3
    run_txn(1'b1, 1'b0, 4'd3, 8'h00, 8'hA5, "rd1_addr3");
    check("rd1_rdata0_untouched", m0.rdata, 0);

    // Both requesters hold reads: acks every 3 cycles at DONE cycles 2,5,8
    m0.req = 1'b1; m0.we = 1'b0; m0.addr = 4'd1;
    m1.req = 1'b1; m1.we = 1'b0; m1.addr = 4'd2;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      exp_ack = 2'b00;
      if (i == 2 || i == 8) exp_ack = 2'b01;
`ifdef MEM_ARB_FIXED_PRIO_EN
      if (i == 5) exp_ack = 2'b01;
`else
      if (i == 5) exp_ack = 2'b10;
`endif
      check($sformatf("tie_acks_c%0d", i), {m1.ack, m0.ack}, exp_ack);
    end
    m0.req = 1'b0;
    m1.req = 1'b0;
    @(negedge clk);
    check("tie_rdata0", m0.rdata, 8'h11);
`ifdef MEM_ARB_FIXED_PRIO_EN
    check("tie_rdata1", m1.rdata, 8'hA5);
`else
    check("tie_rdata1", m1.rdata, 8'h22);
`endif

    // Address boundaries: writes do not alter rdata, no wrap corruption
    run_txn(1'b0, 1'b1, 4'd15, 8'hFF, 8'h11, "wr_addr15");
    run_txn(1'b0, 1'b1, 4'd0,  8'h00, 8'h11, "wr_addr0");
    run_txn(1'b1, 1'b0, 4'd15, 8'h00, 8'hFF, "rd_addr15");
    check("mem_addr0_zero", mem_model[0], 8'h00);

    // Reset during ACCESS of a write of 0x3C to addr 7
    m0.req = 1'b1; m0.we = 1'b1; m0.addr = 4'd7; m0.wdata = 8'h3C;
    @(negedge clk);
    check("abort_access_write", 32'(mem_write), 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_write_dropped", 32'(mem_write), 0);
    check("abort_busy", 32'(busy), 0);
    m0.req = 1'b0;
    @(negedge clk);
    check("abort_no_ack", {m1.ack, m0.ack}, 0);
    check("abort_mem7", mem_model[7], 8'h77);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_after_no_ack", {m1.ack, m0.ack}, 0);
    check("abort_rdata0_cleared", m0.rdata, 0);
    run_txn(1'b1, 1'b0, 4'd7, 8'h00, 8'h77, "rd_addr7_old");

    // Ten idle cycles: nothing moves
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle_c%0d", i),
            {m1.ack, m0.ack, busy, mem_write, mem_address, m1.rdata},
            {1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 8'h77});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
